// File: rtl/step_seq_pkg.sv
// Shared types and the step classification rule for the step sequencer.
package step_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    typedef enum logic [1:0] {
        CLS_IGN  = 2'd0,
        CLS_LIM  = 2'd1,
        CLS_FULL = 2'd2
    } step_class_e;

    // LIMIT is tested first so it wins when the FULL index falls inside the limit band.
    function automatic step_class_e classify(
        input int unsigned idx,
        input int unsigned lim_lo,
        input int unsigned lim_hi,
        input int unsigned full_idx
    );
        if (idx >= lim_lo && idx <= lim_hi) begin
            return CLS_LIM;
        end
        if (idx == full_idx) begin
            return CLS_FULL;
        end
        return CLS_IGN;
    endfunction

endpackage

// File: rtl/step_seq_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/step_seq_ctrl.sv
// Walks a step index over [start_val, end_val), offering each step over valid/ready
// and tallying odd (pass) and even (fail) indices, then pulses done.
//
//   state | meaning
//   IDLE  | waiting for start; tallies hold from the previous run
//   RUN   | offering step_idx downstream, one transfer per ready cycle
//   DONE  | one-cycle done pulse, then back to IDLE
module step_seq_ctrl
    import step_seq_pkg::*;
#(
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned TALLY_W  = 4,
    parameter int unsigned LIM_LO   = 1,
    parameter int unsigned LIM_HI   = 3,
    parameter int unsigned FULL_IDX = 5
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               abort,
    input  logic [CNT_W-1:0]   start_val,
    input  logic [CNT_W-1:0]   end_val,
    output logic               step_valid,
    input  logic               step_ready,
    output logic [CNT_W-1:0]   step_idx,
    output logic [1:0]         step_class,
    output logic [TALLY_W-1:0] pass_cnt,
    output logic [TALLY_W-1:0] fail_cnt,
    output logic               busy,
    output logic               done
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] end_q;
    logic [CNT_W-1:0] idx_q;
    logic             load;
    logic             xfer;
    logic             last;
    step_class_e      cls;

    // Abort suppresses both a pending start and a same-cycle transfer.
    always_comb begin
        load      = (state == ST_IDLE) && start && !abort;
        xfer      = (state == ST_RUN) && step_ready && !abort;
        last      = ((idx_q + CNT_W'(1)) == end_q);
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (load) begin
                    state_nxt = (start_val < end_val) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (xfer && last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (abort) begin
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
            end_q <= '0;
            idx_q <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                end_q <= end_val;
                idx_q <= start_val;
            end else if (xfer) begin
                idx_q <= idx_q + CNT_W'(1);
            end
        end
    end

    sat_counter #(
        .W (TALLY_W)
    ) u_pass_cnt (
        .clk  (clk),
        .rstn (rstn),
        .clr  (load),
        .inc  (xfer && idx_q[0]),
        .q    (pass_cnt)
    );

    sat_counter #(
        .W (TALLY_W)
    ) u_fail_cnt (
        .clk  (clk),
        .rstn (rstn),
        .clr  (load),
        .inc  (xfer && !idx_q[0]),
        .q    (fail_cnt)
    );

    always_comb begin
        cls = classify(32'(idx_q), LIM_LO, LIM_HI, FULL_IDX);
    end

    assign step_class = cls;
    assign step_idx   = idx_q;
    assign step_valid = (state == ST_RUN);
    assign busy       = (state == ST_RUN);
    assign done       = (state == ST_DONE);

endmodule

// File: tb/tb_step_seq_ctrl.sv
// Scoreboard bench for step_seq_ctrl: stimulus pushes expected steps and completions,
// a negedge monitor pops and compares them as the DUT presents transfers and done pulses.
module tb_step_seq_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start;
    logic       abort;
    logic [3:0] start_val;
    logic [3:0] end_val;
    logic       step_ready;

    logic       step_valid;
    logic [3:0] step_idx;
    logic [1:0] step_class;
    logic [3:0] pass_cnt;
    logic [3:0] fail_cnt;
    logic       busy;
    logic       done;

    logic       step_valid2;
    logic [3:0] step_idx2;
    logic [1:0] step_class2;
    logic [1:0] pass_cnt2;
    logic [1:0] fail_cnt2;
    logic       busy2;
    logic       done2;

    step_seq_ctrl #(.CNT_W(4), .TALLY_W(4), .LIM_LO(1), .LIM_HI(3), .FULL_IDX(5)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .abort      (abort),
        .start_val  (start_val),
        .end_val    (end_val),
        .step_valid (step_valid),
        .step_ready (step_ready),
        .step_idx   (step_idx),
        .step_class (step_class),
        .pass_cnt   (pass_cnt),
        .fail_cnt   (fail_cnt),
        .busy       (busy),
        .done       (done)
    );

    // Narrow tallies to exercise saturation on long ranges.
    step_seq_ctrl #(.CNT_W(4), .TALLY_W(2), .LIM_LO(1), .LIM_HI(3), .FULL_IDX(5)) dut2 (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .abort      (abort),
        .start_val  (start_val),
        .end_val    (end_val),
        .step_valid (step_valid2),
        .step_ready (step_ready),
        .step_idx   (step_idx2),
        .step_class (step_class2),
        .pass_cnt   (pass_cnt2),
        .fail_cnt   (fail_cnt2),
        .busy       (busy2),
        .done       (done2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int cls;
    } step_t;

    typedef struct {
        int pass;
        int fail;
        int pass2;
        int fail2;
        int run_cyc;
        int n;
    } done_t;

    step_t exp_steps[$];
    done_t exp_done[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int run_cyc = 0;
    int last_xfer_cyc = 0;
    bit prev_done = 1'b0;
    bit stall_hold = 1'b0;
    int held_idx = 0;
    int held_cls = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int ref_class(input int i);
        if (i >= 1 && i <= 3) return 1;
        if (i == 5) return 2;
        return 0;
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rstn) begin
            prev_done  = 1'b0;
            stall_hold = 1'b0;
            run_cyc    = 0;
        end else begin
            if (stall_hold && step_valid) begin
                chk("stall_idx", int'(step_idx), held_idx);
                chk("stall_cls", int'(step_class), held_cls);
            end
            stall_hold = step_valid && !step_ready && !abort;
            held_idx   = int'(step_idx);
            held_cls   = int'(step_class);

            if (step_valid && step_ready && !abort) begin
                if (exp_steps.size() == 0) begin
                    chk("unexpected_step", int'(step_idx), -1);
                end else begin
                    step_t e;
                    e = exp_steps.pop_front();
                    chk("step_idx", int'(step_idx), e.idx);
                    chk("step_class", int'(step_class), e.cls);
                end
                last_xfer_cyc = cyc;
            end

            if (done) begin
                chk("done_width", int'(prev_done), 0);
                chk("done_valid", int'(step_valid), 0);
                if (exp_done.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    done_t d;
                    d = exp_done.pop_front();
                    chk("pass_cnt", int'(pass_cnt), d.pass);
                    chk("fail_cnt", int'(fail_cnt), d.fail);
                    chk("pass_cnt_sat", int'(pass_cnt2), d.pass2);
                    chk("fail_cnt_sat", int'(fail_cnt2), d.fail2);
                    chk("run_cycles", run_cyc, d.run_cyc);
                    if (d.n > 0) chk("done_latency", cyc - last_xfer_cyc, 1);
                end
                done_cnt++;
            end
            prev_done = done;
            if (busy) run_cyc++;
            else run_cyc = 0;
        end
    end

    // rmode: 0 ready always high, 1 ready toggles 1/0, 2 random ready
    task automatic run_seq(input int sv, input int ev, input int rmode);
        bit rpat[300];
        int n, p, f, ones, rc, k, d0;
        step_t s;
        done_t d;
        for (int i = 0; i < 300; i++) begin
            if (rmode == 0) rpat[i] = 1'b1;
            else if (rmode == 1) rpat[i] = (i % 2 == 0);
            else rpat[i] = (i % 4 == 3) ? 1'b1 : 1'(($urandom % 2));
        end
        n = (ev > sv) ? ev - sv : 0;
        p = 0;
        f = 0;
        for (int i = sv; i < ev; i++) begin
            s.idx = i;
            s.cls = ref_class(i);
            exp_steps.push_back(s);
            if (i % 2 == 1) p++;
            else f++;
        end
        rc = 0;
        ones = 0;
        for (int i = 0; i < 300 && ones < n; i++) begin
            if (rpat[i]) ones++;
            rc = i + 1;
        end
        d.pass = sat(p, 15);
        d.fail = sat(f, 15);
        d.pass2 = sat(p, 3);
        d.fail2 = sat(f, 3);
        d.run_cyc = rc;
        d.n = n;
        exp_done.push_back(d);

        start      = 1'b1;
        start_val  = 4'(sv);
        end_val    = 4'(ev);
        step_ready = 1'(($urandom % 2));
        d0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (done_cnt == d0 && k < 400) begin
            step_ready = (k < 300) ? rpat[k] : 1'b1;
            @(posedge clk); #1;
            k++;
        end
        if (done_cnt == d0) begin
            chk("done_timeout", 0, 1);
        end else begin
            chk("tally_hold_pass", int'(pass_cnt), sat(p, 15));
            chk("tally_hold_fail", int'(fail_cnt), sat(f, 15));
        end
        step_ready = 1'b0;
    endtask

    task automatic run_abort(input int sv, input int ev, input int a);
        int p, f, d0;
        step_t s;
        p = 0;
        f = 0;
        for (int i = sv; i < a; i++) begin
            s.idx = i;
            s.cls = ref_class(i);
            exp_steps.push_back(s);
            if (i % 2 == 1) p++;
            else f++;
        end
        start      = 1'b1;
        start_val  = 4'(sv);
        end_val    = 4'(ev);
        step_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (a - sv) @(posedge clk);
        #1;
        abort = 1'b1;
        d0 = done_cnt;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_valid", int'(step_valid), 0);
        chk("abort_pass", int'(pass_cnt), p);
        chk("abort_fail", int'(fail_cnt), f);
        chk("abort_pass_sat", int'(pass_cnt2), sat(p, 3));
        chk("abort_fail_sat", int'(fail_cnt2), sat(f, 3));
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt, d0);
        step_ready = 1'b0;
    endtask

    task automatic run_reset();
        step_t s;
        for (int i = 0; i < 5; i++) begin
            s.idx = i;
            s.cls = ref_class(i);
            exp_steps.push_back(s);
        end
        start      = 1'b1;
        start_val  = 4'd0;
        end_val    = 4'd12;
        step_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start     = 1'b1;
        start_val = 4'd9;
        end_val   = 4'd10;
        @(posedge clk); #1;
        start     = 1'b0;
        start_val = 4'd0;
        end_val   = 4'd12;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        chk("rst_valid", int'(step_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_idx", int'(step_idx), 0);
        chk("rst_pass", int'(pass_cnt), 0);
        chk("rst_fail", int'(fail_cnt), 0);
        chk("rst_pass_sat", int'(pass_cnt2), 0);
        #5;
        rstn = 1'b1;
        chk("rst_pending_steps", exp_steps.size(), 0);
        step_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int sv, ev, a;
        rstn       = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        start_val  = 4'd0;
        end_val    = 4'd0;
        step_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        chk("reset_valid", int'(step_valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_idx", int'(step_idx), 0);
        chk("reset_pass", int'(pass_cnt), 0);
        chk("reset_fail", int'(fail_cnt), 0);
        @(posedge clk); #1;

        run_seq(0, 6, 0);
        run_seq(0, 6, 1);
        run_seq(7, 7, 0);
        run_seq(0, 15, 0);
        run_abort(0, 6, 3);
        run_seq(2, 9, 2);
        run_reset();
        run_seq(1, 4, 0);

        for (int t = 0; t < 24; t++) begin
            sv = $urandom_range(0, 14);
            ev = $urandom_range(0, 15);
            if ((t % 4 == 3) && (sv < ev)) begin
                a = $urandom_range(sv, ev - 1);
                run_abort(sv, ev, a);
            end else begin
                run_seq(sv, ev, $urandom_range(0, 2));
            end
        end

        repeat (2) @(posedge clk);
        #1;
        chk("leftover_steps", exp_steps.size(), 0);
        chk("leftover_done", exp_done.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
